muldiv_unit_scheduler: RTL and testbench
========================================

Name: muldiv_unit_scheduler

Overview:
- Shared iterative multiply/divide unit with built-in request scheduler. It serves every single_instruction_controller (SIC) port in superscalar_machine.
- Arbitrates among the SIC ports by issue-ID age, with the oldest first. Latches operands, sequences a fixed-latency operation, and returns HI/LO to the owning port.
- Sits beside the ALU pool. Accepts the machine rollback signal as a flush.

Parameters:
- NUM_PORTS, 2, number of SIC requester ports.
- ID_WIDTH, 16, issue-ID width. IDs wrap modulo 2^ID_WIDTH.
- MUL_LATENCY, 4, cycles from grant to done for MULT/MULTU. Must be at least 1.
- DIV_LATENCY, 32, cycles from grant to done for DIV/DIVU. Must be at least 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  rollback. Aborts any in-flight operation.
- req[NUM_PORTS]  in  1 each  port requests the unit.
- req_id[NUM_PORTS]  in  ID_WIDTH each  issue ID of the requesting instruction.
- req_op[NUM_PORTS]  in  2 each  operation: 0=MULTU, 1=MULT, 2=DIVU, 3=DIV.
- src_a[NUM_PORTS]  in  32 each  operand A (rs).
- src_b[NUM_PORTS]  in  32 each  operand B (rt).
- grant[NUM_PORTS]  out  1 each  one-cycle pulse: request accepted, operands latched.
- done[NUM_PORTS]  out  1 each  one-cycle pulse: result valid for this port.
- result_hi  out  32  HI result, registered.
- result_lo  out  32  LO result, registered.
- busy  out  1  unit occupied (state BUSY).

Behaviour:
Reset (async, rst_n=0):
- state=IDLE.
- grant, done, busy = 0.
- result_hi, result_lo = 0.
- Counter and owner cleared.
- Takes effect immediately, including mid-operation. No done is produced afterwards.

State IDLE:
- If flush=0 and any req=1, select the winner, then:
  - pulse grant[winner] for that cycle;
  - latch op and operands;
  - record owner;
  - load counter with the op latency;
  - next state BUSY.
- If no req is asserted, or flush=1, stay IDLE with no grant.

Arbitration:
- Port p is older than port q when (req_id[p] - req_id[q]), taken mod 2^ID_WIDTH and read as signed, is negative. This is a wrap-safe compare.
- The oldest requesting port wins.
- Equal IDs: the lower port index wins.
- Combinational choice, registered grant state.
- A requester must hold req, id, op and operands stable until it sees grant. Non-granted requests simply stay pending.

State BUSY:
- busy=1. The counter decrements each cycle.
- When the counter reaches 1:
  - register the results;
  - pulse done[owner] on the next edge;
  - next state IDLE.
- Latency: grant observed in cycle T means done is observed in cycle T+LAT (LAT = MUL_LATENCY or DIV_LATENCY).
- The earliest next grant is cycle T+LAT+1. Grant and done are never asserted in the same cycle.
- req from any port while BUSY is ignored (no grant).

Result rules:
- MULTU: {hi,lo} = unsigned 64-bit product.
- MULT: {hi,lo} = signed 64-bit product.
- DIVU: lo = a/b, hi = a%b (unsigned).
- DIV: signed division truncating toward zero. Remainder takes the sign of the dividend.
- Divide by zero (DIV or DIVU): lo=32'hFFFF_FFFF, hi=a.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0.
- result_hi and result_lo hold their value until the next done. They are only meaningful when done is high.
- The implementation may be iterative or a pipelined multiplier, provided the latencies match exactly.

Flush:
- flush=1 in any cycle: state becomes IDLE next cycle and busy drops.
- The pending done is suppressed, and no grant is issued that cycle.
- If flush coincides with the final BUSY cycle, done is also suppressed.
- result_hi and result_lo keep their old value.

Invariants:
- At most one grant bit is high per cycle.
- At most one done bit is high per cycle.
- A done is only ever delivered to the recorded owner.

Test Plan:
- Reset then single MULTU:
  - Stimulus: port0 requests a=32'hFFFF_FFFF, b=2.
  - Response: grant[0] at T; done[0] at T+4 with hi=1, lo=32'hFFFF_FFFE; busy high from T+1 to T+4.
- Age arbitration with wrap:
  - Stimulus: port0 id=16'hFFFE, port1 id=16'h0001, both requesting.
  - Response: grant[0] first (older across the wrap). port1 is granted in the first IDLE cycle after done[0].
- Equal IDs and back-to-back:
  - Stimulus: both ports id=5 requesting MULT with a=-3, b=7.
  - Response: port0 is granted first with hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB. Then port1 gets the same result; its grant comes one cycle after done[0].
- Division corner cases:
  - DIV -7/2: lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF, done at T+32.
  - DIVU 9/0: lo=32'hFFFF_FFFF, hi=9.
  - DIV 32'h8000_0000/-1: lo=32'h8000_0000, hi=0.
- Flush mid-operation:
  - Stimulus: start DIVU, then assert flush at T+10.
  - Response: busy=0 at T+11; no done at T+32; a new request is granted at T+11 or later; result_hi and result_lo are unchanged.
- Async reset mid-BUSY:
  - Stimulus: drop rst_n between clock edges during a MULT.
  - Response: all outputs are 0 immediately; no done after rst_n releases; normal grant afterwards.

Source files
------------

// File: rtl/muldiv_unit_scheduler.sv
// Shared multiply/divide unit for the SIC ports. The oldest requester by issue ID wins.
// The unit runs one operation at a time with a fixed latency and returns HI/LO to the owning port.
module muldiv_unit_scheduler #(
    parameter int NUM_PORTS   = 2,
    parameter int ID_WIDTH    = 16,
    parameter int MUL_LATENCY = 4,
    parameter int DIV_LATENCY = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [ID_WIDTH-1:0]  req_id [NUM_PORTS],
    input  logic [1:0]           req_op [NUM_PORTS],
    input  logic [31:0]          src_a  [NUM_PORTS],
    input  logic [31:0]          src_b  [NUM_PORTS],
    output logic [NUM_PORTS-1:0] grant,
    output logic [NUM_PORTS-1:0] done,
    output logic [31:0]          result_hi,
    output logic [31:0]          result_lo,
    output logic                 busy
);
    // state | meaning
    // IDLE  | waiting for a request, grant issued combinationally
    // BUSY  | operation in flight, counter runs LAT..1, done asserted on count 1
    localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam int OWN_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LATENCY);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [OWN_W-1:0]  owner, winner;
    logic              any_req;
    logic [1:0]        op_q, op_s;
    logic [31:0]       a_q, b_q, a_s, b_s;
    logic [31:0]       quo_s, rem_s;
    logic [63:0]       res_s;
    logic              load_res;

    function automatic logic older(input logic [ID_WIDTH-1:0] x, input logic [ID_WIDTH-1:0] y);
        logic [ID_WIDTH-1:0] d;
        d = x - y;
        return $signed(d) < 0;
    endfunction

    // Strictly-older compare keeps the lower index on equal IDs.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (req[p]) begin
                if (!any_req || older(req_id[p], req_id[winner]))
                    winner = OWN_W'(p);
                any_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (flush) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    state_next = BUSY;
                    cnt_next   = req_op[winner][1] ? DIV_CNT : MUL_CNT;
                end
                BUSY: if (cnt == CNT_ONE) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt - CNT_ONE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        grant = '0;
        done  = '0;
        busy  = (state == BUSY);
        if (rst_n && state == IDLE && !flush && any_req)
            grant[winner] = 1'b1;
        if (state == BUSY && cnt == CNT_ONE && !flush)
            done[owner] = 1'b1;
    end

    // Operands come straight from the winner on the grant cycle so a latency of 1 still works.
    assign op_s     = (state == IDLE) ? req_op[winner] : op_q;
    assign a_s      = (state == IDLE) ? src_a[winner]  : a_q;
    assign b_s      = (state == IDLE) ? src_b[winner]  : b_q;
    assign load_res = (state_next == BUSY) && (cnt_next == CNT_ONE);

    always_comb begin
        quo_s = 32'hFFFF_FFFF;
        rem_s = a_s;
        if (b_s != 32'd0) begin
            if (op_s[0]) begin
                if (a_s == 32'h8000_0000 && b_s == 32'hFFFF_FFFF) begin
                    quo_s = 32'h8000_0000;
                    rem_s = 32'd0;
                end else begin
                    quo_s = $signed(a_s) / $signed(b_s);
                    rem_s = $signed(a_s) % $signed(b_s);
                end
            end else begin
                quo_s = a_s / b_s;
                rem_s = a_s % b_s;
            end
        end
        case (op_s)
            2'd0:    res_s = 64'(a_s) * 64'(b_s);
            2'd1:    res_s = {{32{a_s[31]}}, a_s} * {{32{b_s[31]}}, b_s};
            default: res_s = {rem_s, quo_s};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_hi <= '0;
            result_lo <= '0;
        end else begin
            if (state == IDLE && state_next == BUSY) begin
                owner <= winner;
                op_q  <= req_op[winner];
                a_q   <= src_a[winner];
                b_q   <= src_b[winner];
            end
            if (load_res)
                {result_hi, result_lo} <= res_s;
        end
    end
endmodule

// File: tb/tb_muldiv_unit_scheduler.sv
// Directed bench for muldiv_unit_scheduler: arbitration, latency, results, flush and async reset.
module tb_muldiv_unit_scheduler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [1:0]  req;
    logic [15:0] req_id [2];
    logic [1:0]  req_op [2];
    logic [31:0] src_a  [2];
    logic [31:0] src_b  [2];
    logic [1:0]  grant, done;
    logic [31:0] result_hi, result_lo;
    logic        busy;
    int          nerr = 0;
    int          nchk = 0;

    muldiv_unit_scheduler #(.NUM_PORTS(2), .ID_WIDTH(16), .MUL_LATENCY(4), .DIV_LATENCY(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .req(req), .req_id(req_id), .req_op(req_op),
        .src_a(src_a), .src_b(src_b), .grant(grant), .done(done),
        .result_hi(result_hi), .result_lo(result_lo), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in cycle T+1; counts cycles from the grant cycle T until a done appears.
    task automatic wait_done(input string tag, input int lat, input logic [1:0] exp_done);
        int n = 1;
        while (done == 2'b00 && n < 80) begin
            tick();
            #1;
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " done"}, 64'(done), 64'(exp_done));
    endtask

    // Entered in an IDLE cycle just after tick(); leaves one cycle after done.
    task automatic run_op(input string tag, input int p, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [1:0] pm;
        pm = 2'b01 << p;
        req_id[p] = 16'd100; req_op[p] = op; src_a[p] = a; src_b[p] = b;
        req[p] = 1'b1;
        #1;
        check({tag, " grant"}, 64'(grant), 64'(pm));
        check({tag, " busy@T"}, 64'(busy), 64'd0);
        tick();
        req[p] = 1'b0;
        #1;
        check({tag, " busy@T+1"}, 64'(busy), 64'd1);
        wait_done(tag, lat, pm);
        check({tag, " busy@done"}, 64'(busy), 64'd1);
        check({tag, " hi"}, 64'(result_hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(result_lo), 64'(exp_lo));
        tick();
        #1;
        check({tag, " busy after"}, 64'(busy), 64'd0);
        check({tag, " done after"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [1:0] seen;
        rst_n = 1'b0; flush = 1'b0; req = 2'b00;
        for (int i = 0; i < 2; i++) begin
            req_id[i] = '0; req_op[i] = '0; src_a[i] = '0; src_b[i] = '0;
        end
        #12;
        check("reset busy", 64'(busy), 64'd0);
        check("reset grant", 64'(grant), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi", 64'(result_hi), 64'd0);
        check("reset lo", 64'(result_lo), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        run_op("multu", 0, 2'd0, 32'hFFFF_FFFF, 32'd2, 4, 32'd1, 32'hFFFF_FFFE);

        // Wrap-safe age: FFFE is older than 0001.
        req_id[0] = 16'hFFFE; req_op[0] = 2'd0; src_a[0] = 32'd3; src_b[0] = 32'd5;
        req_id[1] = 16'h0001; req_op[1] = 2'd0; src_a[1] = 32'd6; src_b[1] = 32'd7;
        req = 2'b11;
        #1;
        check("wrap grant0", 64'(grant), 64'b01);
        tick();
        req[0] = 1'b0;
        #1;
        check("wrap busy ignores req", 64'(grant), 64'd0);
        wait_done("wrap p0", 4, 2'b01);
        check("wrap p0 lo", 64'(result_lo), 64'd15);
        tick();
        #1;
        check("wrap grant1", 64'(grant), 64'b10);
        tick();
        req[1] = 1'b0;
        #1;
        wait_done("wrap p1", 4, 2'b10);
        check("wrap p1 lo", 64'(result_lo), 64'd42);
        tick();

        // Equal IDs: lower index first, second grant right after done.
        for (int i = 0; i < 2; i++) begin
            req_id[i] = 16'd5; req_op[i] = 2'd1; src_a[i] = 32'hFFFF_FFFD; src_b[i] = 32'd7;
        end
        req = 2'b11;
        #1;
        check("eq grant0", 64'(grant), 64'b01);
        tick();
        req[0] = 1'b0;
        #1;
        wait_done("eq p0", 4, 2'b01);
        check("eq p0 hi", 64'(result_hi), 64'hFFFF_FFFF);
        check("eq p0 lo", 64'(result_lo), 64'hFFFF_FFEB);
        tick();
        #1;
        check("eq grant1", 64'(grant), 64'b10);
        tick();
        req[1] = 1'b0;
        #1;
        wait_done("eq p1", 4, 2'b10);
        check("eq p1 hi", 64'(result_hi), 64'hFFFF_FFFF);
        check("eq p1 lo", 64'(result_lo), 64'hFFFF_FFEB);
        tick();

        run_op("divu by 0", 0, 2'd2, 32'd9, 32'd0, 32, 32'd9, 32'hFFFF_FFFF);
        run_op("div ovf", 1, 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32, 32'd0, 32'h8000_0000);
        run_op("div -7/2", 0, 2'd3, 32'hFFFF_FFF9, 32'd2, 32, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // Flush at T+10 of a DIVU.
        req_op[0] = 2'd2; src_a[0] = 32'd100; src_b[0] = 32'd7; req[0] = 1'b1;
        #1;
        check("flush grant", 64'(grant), 64'b01);
        tick();
        req[0] = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        flush = 1'b1;
        #1;
        check("flush done@T+10", 64'(done), 64'd0);
        tick();
        flush = 1'b0;
        #1;
        check("flush busy@T+11", 64'(busy), 64'd0);
        check("flush hi kept", 64'(result_hi), 64'hFFFF_FFFF);
        check("flush lo kept", 64'(result_lo), 64'hFFFF_FFFD);
        run_op("after flush", 1, 2'd0, 32'h0001_0000, 32'h0001_0000, 4, 32'd1, 32'd0);
        seen = 2'b00;
        for (int i = 0; i < 20; i++) begin
            tick();
            #1;
            seen = seen | done;
        end
        check("flush no late done", 64'(seen), 64'd0);

        // Async reset between edges while a MULT is in flight.
        req_op[1] = 2'd1; src_a[1] = 32'd5; src_b[1] = 32'd6; req[1] = 1'b1;
        #1;
        check("rst op grant", 64'(grant), 64'b10);
        tick();
        req[1] = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        req[0] = 1'b1;
        #1;
        check("rst busy", 64'(busy), 64'd0);
        check("rst grant", 64'(grant), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst hi", 64'(result_hi), 64'd0);
        check("rst lo", 64'(result_lo), 64'd0);
        tick();
        req[0] = 1'b0;
        rst_n = 1'b1;
        seen = 2'b00;
        for (int i = 0; i < 8; i++) begin
            tick();
            #1;
            seen = seen | done;
        end
        check("rst no done", 64'(seen), 64'd0);
        run_op("after rst", 0, 2'd0, 32'd7, 32'd8, 4, 32'd0, 32'd56);

        // Flush while IDLE blocks the grant for that cycle only.
        req[0] = 1'b1; flush = 1'b1;
        #1;
        check("idle flush grant", 64'(grant), 64'd0);
        tick();
        flush = 1'b0;
        #1;
        check("idle flush busy", 64'(busy), 64'd0);
        check("idle flush then grant", 64'(grant), 64'b01);
        tick();
        req[0] = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
